register_stack_p: RTL and testbench
===================================

Name: register_stack_p

Overview:
- Parametrised successor to the processor's register stack: an operand stack of DEPTH entries, each WIDTH bits wide.
- Top two entries are visible combinationally on a/b, so the datapath can compute w from them in the same cycle.
- Adds DUP/OVER/ROT/REPLACE1/CLEAR ops, a depth count, full/empty flags, and sticky overflow/underflow error flags.
- Sits between the control unit (drives stackOP) and the ALU (consumes a/b, returns w).

Parameters:
- WIDTH, 16, bits per entry.
- DEPTH, 8, number of entries; legal range 3..64.
- CNTW, 7, width of the depth port; must satisfy 2^CNTW > DEPTH.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- stackOP  input  4  operation code, sampled on the rising edge.
- w  input  WIDTH  write data for PUSH/REPLACE1/REPLACE2.
- a  output  WIDTH  top of stack (entry 0).
- b  output  WIDTH  second entry (entry 1).
- depth  output  CNTW  number of valid entries, 0..DEPTH.
- empty  output  1  depth==0.
- full  output  1  depth==DEPTH.
- ovf  output  1  sticky overflow error.
- unf  output  1  sticky underflow / illegal-op error.

Behaviour:
- Storage: entries s[0..DEPTH-1]; s[0] is the top. a=s[0], b=s[1], both combinational. Invalid entries always hold 0.
- Reset (RST=1 at an edge): all entries 0, depth=0, ovf=0, unf=0. RST overrides any op in the same cycle, including reset mid-sequence.
- Every op occupies one cycle; results are visible on a/b/depth immediately after the edge.
- Op encoding, with required depth in brackets:
- 0 NOP [0]: no change.
- 1 PUSH [0, not full]: shift down; s[0]=w; depth+1.
- 2 REPLACE2 [2]: pop two, push w; s[0]=w, s[1..]=old s[2..], vacated bottom entry=0; depth-1.
- 3 POP [1]: shift up, bottom=0; depth-1.
- 4 POP2 [2]: shift up by two, bottom two entries=0; depth-2.
- 5 SWAP [2]: exchange s[0] and s[1].
- 6 DUP [1, not full]: push old s[0]; depth+1.
- 7 OVER [2, not full]: push old s[1]; depth+1.
- 8 REPLACE1 [1]: s[0]=w; depth unchanged.
- 9 ROT [3]: s[0]=old s[2], s[1]=old s[0], s[2]=old s[1].
- 10 CLEAR [0]: all entries 0, depth=0. ovf/unf not cleared.
- 11..15: illegal.
- Failed op (insufficient depth, or not-full requirement violated): no change to entries or depth.
- Error flags: failed depth requirement or illegal code sets unf; PUSH/DUP/OVER while full sets ovf. Both are sticky until RST.
- A failure sets its flag on the same edge the op is rejected.
- Error flag outputs are registered; a/b/empty/full are derived combinationally from state.
- Bottom-of-stack shifts discard nothing while full, because pushes are rejected when full.
- No bypass: w is sampled at the edge; ops never chain within a cycle.

Test Plan:
- RST, then PUSH 1,2,3,4 -> a=4, b=3, depth=4; REPLACE2 w=b+a=7 -> a=7, b=2, depth=3; REPLACE2 w=b-a (2-7=0xFFFB) -> a=0xFFFB, b=1, depth=2.
- From a=0xFFFB, b=1: PUSH 7, SWAP -> a=0xFFFB, b=7, depth=3; POP2 -> a=1, b=0, depth=1; ovf=0, unf=0.
- Fill DEPTH=8 with PUSH 1..8 -> full=1, a=8; PUSH 9 -> no change, ovf=1, depth=8; DUP -> still no change; CLEAR -> depth=0, empty=1, a=0, ovf still 1.
- From empty: POP -> unf=1, depth=0; stackOP=12 -> unf stays 1, no change; RST -> unf=0, ovf=0.
- PUSH 10,20,30; ROT -> a=10, b=30, s[2]=20; OVER -> a=30, depth=4; DUP -> a=30, b=30, depth=5; REPLACE1 w=5 -> a=5, depth=5.
- PUSH 1,2 then RST asserted together with PUSH 3 -> depth=0, a=0, b=0, empty=1.

Source files
------------

// File: rtl/register_stack_p.sv
// register_stack_p
// Operand stack of DEPTH entries, WIDTH bits each. Entry 0 is the top of the
// stack. The top two entries are presented combinationally so the ALU can
// compute a result from them and return it on w in the same cycle.
//
// Ports:
//   CLK      in   clock, all state updates on the rising edge
//   RST      in   synchronous active-high reset, overrides any op
//   stackOP  in   4-bit operation code, sampled on the rising edge
//   w        in   WIDTH write data for PUSH / REPLACE1 / REPLACE2
//   a        out  WIDTH entry 0 (top)
//   b        out  WIDTH entry 1
//   depth    out  CNTW number of valid entries, 0..DEPTH
//   empty    out  depth == 0
//   full     out  depth == DEPTH
//   ovf      out  sticky overflow (PUSH/DUP/OVER while full)
//   unf      out  sticky underflow / illegal opcode
module register_stack_p #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNTW  = 7
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       stackOP,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [CNTW-1:0]  depth,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  typedef enum logic [3:0] {
    OP_NOP      = 4'd0,
    OP_PUSH     = 4'd1,
    OP_REPLACE2 = 4'd2,
    OP_POP      = 4'd3,
    OP_POP2     = 4'd4,
    OP_SWAP     = 4'd5,
    OP_DUP      = 4'd6,
    OP_OVER     = 4'd7,
    OP_REPLACE1 = 4'd8,
    OP_ROT      = 4'd9,
    OP_CLEAR    = 4'd10
  } op_e;

  logic [WIDTH-1:0] s_q [DEPTH];
  logic [WIDTH-1:0] s_d [DEPTH];
  logic [CNTW-1:0]  depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Pre-shifted copies of the stack; the op decoder only selects among them.
  logic [WIDTH-1:0] push_v [DEPTH];  // shifted down one, top slot free
  logic [WIDTH-1:0] up1_v  [DEPTH];  // shifted up one, bottom zero-filled
  logic [WIDTH-1:0] up2_v  [DEPTH];  // shifted up two, bottom two zero-filled

  logic             full_c;
  logic             has1, has2, has3;
  op_e              op;

  assign op     = op_e'(stackOP);
  assign full_c = (depth_q == CNTW'(DEPTH));
  assign has1   = (depth_q >= CNTW'(1));
  assign has2   = (depth_q >= CNTW'(2));
  assign has3   = (depth_q >= CNTW'(3));

  always_comb begin
    push_v[0] = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      push_v[i] = s_q[i-1];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      up1_v[i] = s_q[i+1];
    end
    up1_v[DEPTH-1] = '0;
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH - 2; i++) begin
      up2_v[i] = s_q[i+2];
    end
    up2_v[DEPTH-2] = '0;
    up2_v[DEPTH-1] = '0;
  end

  always_comb begin
    s_d     = s_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    unique case (op)
      OP_NOP: ;

      OP_PUSH: begin
        if (full_c) begin
          ovf_d = 1'b1;
        end else begin
          s_d     = push_v;
          s_d[0]  = w;
          depth_d = depth_q + CNTW'(1);
        end
      end

      OP_REPLACE2: begin
        if (!has2) begin
          unf_d = 1'b1;
        end else begin
          // Pop two then push w: equivalent to shift-up-one with a new top.
          s_d     = up1_v;
          s_d[0]  = w;
          depth_d = depth_q - CNTW'(1);
        end
      end

      OP_POP: begin
        if (!has1) begin
          unf_d = 1'b1;
        end else begin
          s_d     = up1_v;
          depth_d = depth_q - CNTW'(1);
        end
      end

      OP_POP2: begin
        if (!has2) begin
          unf_d = 1'b1;
        end else begin
          s_d     = up2_v;
          depth_d = depth_q - CNTW'(2);
        end
      end

      OP_SWAP: begin
        if (!has2) begin
          unf_d = 1'b1;
        end else begin
          s_d[0] = s_q[1];
          s_d[1] = s_q[0];
        end
      end

      OP_DUP: begin
        if (!has1) begin
          unf_d = 1'b1;
        end else if (full_c) begin
          ovf_d = 1'b1;
        end else begin
          s_d     = push_v;
          s_d[0]  = s_q[0];
          depth_d = depth_q + CNTW'(1);
        end
      end

      OP_OVER: begin
        if (!has2) begin
          unf_d = 1'b1;
        end else if (full_c) begin
          ovf_d = 1'b1;
        end else begin
          s_d     = push_v;
          s_d[0]  = s_q[1];
          depth_d = depth_q + CNTW'(1);
        end
      end

      OP_REPLACE1: begin
        if (!has1) begin
          unf_d = 1'b1;
        end else begin
          s_d[0] = w;
        end
      end

      OP_ROT: begin
        if (!has3) begin
          unf_d = 1'b1;
        end else begin
          s_d[0] = s_q[2];
          s_d[1] = s_q[0];
          s_d[2] = s_q[1];
        end
      end

      OP_CLEAR: begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          s_d[i] = '0;
        end
        depth_d = '0;
      end

      default: unf_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        s_q[i] <= '0;
      end
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      s_q     <= s_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign a     = s_q[0];
  assign b     = s_q[1];
  assign depth = depth_q;
  assign empty = (depth_q == '0);
  assign full  = full_c;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_register_stack_p.sv
module tb_register_stack_p;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CNTW  = 7;

  localparam logic [3:0] NOP = 4'd0, PUSH = 4'd1, REP2 = 4'd2, POP = 4'd3,
                         POP2 = 4'd4, SWAP = 4'd5, DUP = 4'd6, OVER = 4'd7,
                         REP1 = 4'd8, ROT = 4'd9, CLR = 4'd10;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [3:0]       stackOP = 4'd0;
  logic [WIDTH-1:0] w = '0;
  logic [WIDTH-1:0] a, b;
  logic [CNTW-1:0]  depth;
  logic             empty, full, ovf, unf;

  register_stack_p #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST(RST), .stackOP(stackOP), .w(w),
    .a(a), .b(b), .depth(depth), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [CNTW-1:0]  d;
    logic             e;
    logic             f;
    logic             o;
    logic             u;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  // Drive one op for one cycle and queue the hand-computed post-edge state.
  task automatic op(input logic r, input logic [3:0] code, input logic [WIDTH-1:0] wv,
                    input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                    input int ed, input logic eo, input logic eu);
    exp_t x;
    @(negedge CLK);
    RST     = r;
    stackOP = code;
    w       = wv;
    @(posedge CLK);
    #1;
    x.a = ea;
    x.b = eb;
    x.d = CNTW'(ed);
    x.e = (ed == 0);
    x.f = (ed == DEPTH);
    x.o = eo;
    x.u = eu;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input int s, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step %0d %s: got %0h expected %0h", s, name, act, req);
    end
  endtask

  // Monitor: the DUT presents a new state after every edge; compare at the
  // following falling edge against the oldest queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        x = q.pop_front();
        step++;
        chk("a",     step, 32'(a),     32'(x.a));
        chk("b",     step, 32'(b),     32'(x.b));
        chk("depth", step, 32'(depth), 32'(x.d));
        chk("empty", step, 32'(empty), 32'(x.e));
        chk("full",  step, 32'(full),  32'(x.f));
        chk("ovf",   step, 32'(ovf),   32'(x.o));
        chk("unf",   step, 32'(unf),   32'(x.u));
      end
    end
  end

  initial begin
    // reset and arithmetic-style sequence
    op(1, NOP,  0,      0,      0,      0, 0, 0);
    op(0, PUSH, 1,      1,      0,      1, 0, 0);
    op(0, PUSH, 2,      2,      1,      2, 0, 0);
    op(0, PUSH, 3,      3,      2,      3, 0, 0);
    op(0, PUSH, 4,      4,      3,      4, 0, 0);
    op(0, REP2, 7,      7,      2,      3, 0, 0);
    op(0, REP2, 16'hFFFB, 16'hFFFB, 1,  2, 0, 0);
    op(0, PUSH, 7,      7,      16'hFFFB, 3, 0, 0);
    op(0, SWAP, 0,      16'hFFFB, 7,    3, 0, 0);
    op(0, NOP,  9,      16'hFFFB, 7,    3, 0, 0);
    op(0, POP2, 0,      1,      0,      1, 0, 0);
    op(0, CLR,  0,      0,      0,      0, 0, 0);

    // fill to full, then overflow attempts
    for (int k = 1; k <= DEPTH; k++) begin
      op(0, PUSH, WIDTH'(k), WIDTH'(k), WIDTH'(k-1), k, 0, 0);
    end
    op(0, PUSH, 9, 8, 7, 8, 1, 0);
    op(0, DUP,  0, 8, 7, 8, 1, 0);
    op(0, OVER, 0, 8, 7, 8, 1, 0);
    op(0, CLR,  0, 0, 0, 0, 1, 0);

    // underflow and illegal code
    op(0, POP,   0, 0, 0, 0, 1, 1);
    op(0, 4'd12, 0, 0, 0, 0, 1, 1);
    op(1, NOP,   0, 0, 0, 0, 0, 0);
    op(0, DUP,   0, 0, 0, 0, 0, 1);
    op(1, NOP,   0, 0, 0, 0, 0, 0);

    // ROT / OVER / DUP / REPLACE1, then drain to expose deeper entries
    op(0, PUSH, 10, 10, 0,  1, 0, 0);
    op(0, PUSH, 20, 20, 10, 2, 0, 0);
    op(0, PUSH, 30, 30, 20, 3, 0, 0);
    op(0, ROT,  0,  10, 30, 3, 0, 0);
    op(0, OVER, 0,  30, 10, 4, 0, 0);
    op(0, DUP,  0,  30, 30, 5, 0, 0);
    op(0, REP1, 5,  5,  30, 5, 0, 0);
    op(0, POP,  0,  30, 10, 4, 0, 0);
    op(0, POP,  0,  10, 30, 3, 0, 0);
    op(0, POP,  0,  30, 20, 2, 0, 0);
    op(0, POP,  0,  20, 0,  1, 0, 0);
    op(0, POP,  0,  0,  0,  0, 0, 0);

    // insufficient-depth rejections leave contents intact
    op(0, PUSH, 5, 5, 0, 1, 0, 0);
    op(0, REP2, 9, 5, 0, 1, 0, 1);
    op(0, SWAP, 0, 5, 0, 1, 0, 1);
    op(0, PUSH, 6, 6, 5, 2, 0, 1);
    op(0, ROT,  0, 6, 5, 2, 0, 1);
    op(0, OVER, 0, 5, 6, 3, 0, 1);

    // reset wins over a simultaneous PUSH
    op(1, NOP,  0, 0, 0, 0, 0, 0);
    op(0, PUSH, 1, 1, 0, 1, 0, 0);
    op(0, PUSH, 2, 2, 1, 2, 0, 0);
    op(1, PUSH, 3, 0, 0, 0, 0, 0);

    @(negedge CLK);
    RST     = 1'b0;
    stackOP = NOP;
    repeat (3) @(posedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
